// File: rtl/fitness_report_tx_pkg.sv
// Shared types and constants for the fitness report serial transmitter.
package fitness_report_tx_pkg;

  // Byte serializer states.
  typedef enum logic [1:0] {
    StIdle,
    StStartBit,
    StDataBits,
    StStopBit
  } tx_state_e;

  localparam int unsigned FRAME_BYTES      = 16;
  localparam logic [7:0]  HDR_BYTE_DEFAULT = 8'hA5;

  // Position of each field within the frame.
  localparam logic [3:0] IDX_HDR        = 4'd0;
  localparam logic [3:0] IDX_SEC_RUN    = 4'd1;
  localparam logic [3:0] IDX_SEC_WALK   = 4'd2;
  localparam logic [3:0] IDX_SEC_CYCLE  = 4'd3;
  localparam logic [3:0] IDX_CAL_RUN_H  = 4'd4;
  localparam logic [3:0] IDX_CAL_RUN_M  = 4'd5;
  localparam logic [3:0] IDX_CAL_RUN_L  = 4'd6;
  localparam logic [3:0] IDX_CAL_WALK_H = 4'd7;
  localparam logic [3:0] IDX_CAL_WALK_M = 4'd8;
  localparam logic [3:0] IDX_CAL_WALK_L = 4'd9;
  localparam logic [3:0] IDX_CAL_CYC_H  = 4'd10;
  localparam logic [3:0] IDX_CAL_CYC_M  = 4'd11;
  localparam logic [3:0] IDX_CAL_CYC_L  = 4'd12;
  localparam logic [3:0] IDX_SPEED      = 4'd13;
  localparam logic [3:0] IDX_THR        = 4'd14;
  localparam logic [3:0] IDX_CHK        = 4'd15;
  localparam logic [3:0] IDX_LAST       = 4'(FRAME_BYTES - 1);

endpackage

// File: rtl/report_uart_byte_tx.sv
// Single-byte 8N1 serializer. A byte loaded while ready_o is high starts its
// start bit on that same edge, so loads at the end of a stop bit chain bytes
// with no idle gap.
module report_uart_byte_tx
  import fitness_report_tx_pkg::*;
#(
  parameter int unsigned ClksPerBit = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic [7:0] data_i,
  output logic       ready_o,
  output logic       byte_done_o,
  output logic       tx_o
);

  localparam logic [15:0] CntLast = 16'(ClksPerBit - 1);

  tx_state_e   state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  data_q, data_d;
  logic        tx_q, tx_d;
  logic        bit_end;

  assign bit_end = (cnt_q == CntLast);
  assign tx_o    = tx_q;

  // State register; tx idles high and is forced high by reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      tx_q    <= tx_d;
    end
  end

  // Next-state: baud counter, bit index and bit-phase sequencing.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    data_d  = data_q;
    unique case (state_q)
      StIdle: begin
        if (load_i) begin
          state_d = StStartBit;
          cnt_d   = '0;
          data_d  = data_i;
        end
      end
      StStartBit: begin
        if (bit_end) begin
          state_d = StDataBits;
          cnt_d   = '0;
          bit_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StDataBits: begin
        if (bit_end) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            state_d = StStopBit;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StStopBit: begin
        if (bit_end) begin
          cnt_d = '0;
          if (load_i) begin
            state_d = StStartBit;
            data_d  = data_i;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs: handshake flags and the next registered line level.
  always_comb begin
    ready_o     = (state_q == StIdle) || ((state_q == StStopBit) && bit_end);
    byte_done_o = (state_q == StStopBit) && bit_end;
    unique case (state_d)
      StIdle:     tx_d = 1'b1;
      StStartBit: tx_d = 1'b0;
      StDataBits: tx_d = data_d[bit_d];
      StStopBit:  tx_d = 1'b1;
      default:    tx_d = 1'b1;
    endcase
  end

endmodule

// File: rtl/fitness_report_tx.sv
// Fitness report frame transmitter: snapshots the measurements on start,
// then streams header, 14 payload bytes and a running checksum back-to-back.
module fitness_report_tx
  import fitness_report_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter logic [7:0]  HDR_BYTE     = HDR_BYTE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  seconds_run,
  input  logic [7:0]  seconds_walk,
  input  logic [7:0]  seconds_cycle,
  input  logic [23:0] calories_run,
  input  logic [23:0] calories_walk,
  input  logic [23:0] calories_cycle,
  input  logic [7:0]  speed,
  input  logic [7:0]  thr,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [3:0]  byte_idx_q, byte_idx_d;
  logic [7:0]  chk_q, chk_d;
  logic [7:0]  sec_run_q, sec_walk_q, sec_cyc_q, speed_q, thr_q;
  logic [23:0] cal_run_q, cal_walk_q, cal_cyc_q;

  logic        accept;
  logic        ser_load, ser_ready, ser_done;
  logic [7:0]  ser_data;
  logic [3:0]  next_idx;
  logic [7:0]  next_byte;

  assign accept   = start && !busy_q && ser_ready;
  assign next_idx = byte_idx_q + 4'd1;
  assign busy     = busy_q;
  assign done     = done_q;

  // Control and checksum registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      byte_idx_q <= '0;
      chk_q      <= '0;
    end else begin
      busy_q     <= busy_d;
      done_q     <= done_d;
      byte_idx_q <= byte_idx_d;
      chk_q      <= chk_d;
    end
  end

  // Measurement snapshot, captured only on the accepting edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sec_run_q  <= '0;
      sec_walk_q <= '0;
      sec_cyc_q  <= '0;
      cal_run_q  <= '0;
      cal_walk_q <= '0;
      cal_cyc_q  <= '0;
      speed_q    <= '0;
      thr_q      <= '0;
    end else if (accept) begin
      sec_run_q  <= seconds_run;
      sec_walk_q <= seconds_walk;
      sec_cyc_q  <= seconds_cycle;
      cal_run_q  <= calories_run;
      cal_walk_q <= calories_walk;
      cal_cyc_q  <= calories_cycle;
      speed_q    <= speed;
      thr_q      <= thr;
    end
  end

  // Frame byte selected for the next position.
  always_comb begin
    case (next_idx)
      IDX_HDR:        next_byte = HDR_BYTE;
      IDX_SEC_RUN:    next_byte = sec_run_q;
      IDX_SEC_WALK:   next_byte = sec_walk_q;
      IDX_SEC_CYCLE:  next_byte = sec_cyc_q;
      IDX_CAL_RUN_H:  next_byte = cal_run_q[23:16];
      IDX_CAL_RUN_M:  next_byte = cal_run_q[15:8];
      IDX_CAL_RUN_L:  next_byte = cal_run_q[7:0];
      IDX_CAL_WALK_H: next_byte = cal_walk_q[23:16];
      IDX_CAL_WALK_M: next_byte = cal_walk_q[15:8];
      IDX_CAL_WALK_L: next_byte = cal_walk_q[7:0];
      IDX_CAL_CYC_H:  next_byte = cal_cyc_q[23:16];
      IDX_CAL_CYC_M:  next_byte = cal_cyc_q[15:8];
      IDX_CAL_CYC_L:  next_byte = cal_cyc_q[7:0];
      IDX_SPEED:      next_byte = speed_q;
      IDX_THR:        next_byte = thr_q;
      IDX_CHK:        next_byte = chk_q;
      default:        next_byte = HDR_BYTE;
    endcase
  end

  // Byte sequencing: header on accept, next byte at each serializer byte end.
  always_comb begin
    busy_d     = busy_q;
    done_d     = 1'b0;
    byte_idx_d = byte_idx_q;
    chk_d      = chk_q;
    ser_load   = 1'b0;
    ser_data   = HDR_BYTE;
    if (accept) begin
      busy_d     = 1'b1;
      byte_idx_d = IDX_HDR;
      chk_d      = '0;
      ser_load   = 1'b1;
      ser_data   = HDR_BYTE;
    end else if (busy_q && ser_done) begin
      if (byte_idx_q == IDX_LAST) begin
        busy_d     = 1'b0;
        done_d     = 1'b1;
        byte_idx_d = '0;
      end else begin
        byte_idx_d = next_idx;
        ser_load   = 1'b1;
        ser_data   = next_byte;
        // Checksum covers payload only; the checksum byte itself is excluded.
        if (next_idx != IDX_CHK) begin
          chk_d = chk_q + next_byte;
        end
      end
    end
  end

  report_uart_byte_tx #(
    .ClksPerBit(CLKS_PER_BIT)
  ) u_byte_tx (
    .clk_i      (clk),
    .rst_i      (rst),
    .load_i     (ser_load),
    .data_i     (ser_data),
    .ready_o    (ser_ready),
    .byte_done_o(ser_done),
    .tx_o       (tx)
  );

endmodule
